// File: rtl/keypad_pkg.sv
// Shared types and helpers for the keypad debounce/decode stage.
// RELEASE state is present only when KEYPAD_RELEASE_DEBOUNCE_EN is defined.
package keypad_pkg;

`ifdef KEYPAD_RELEASE_DEBOUNCE_EN
    typedef enum logic [1:0] {StIdle, StDebounce, StHeld, StRelease} kd_state_t;
`else
    typedef enum logic [1:0] {StIdle, StDebounce, StHeld} kd_state_t;
`endif

    // Indexed by {row, col}; entry 0 (row 0, col 0) sits in the low nibble.
    localparam logic [63:0] KeyMap = {
        4'hD, 4'hF, 4'h0, 4'hE,
        4'hC, 4'h9, 4'h8, 4'h7,
        4'hB, 4'h6, 4'h5, 4'h4,
        4'hA, 4'h3, 4'h2, 4'h1
    };

    function automatic logic onehot4(input logic [3:0] v);
        return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
    endfunction

    function automatic logic [3:0] key_lookup(input logic [1:0] row, input logic [1:0] col);
        return KeyMap[{row, col, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/keypad_decode.sv
// Combinational {col, row} press-code decoder: hex key value plus one-hot legality flag.
module keypad_decode
    import keypad_pkg::*;
(
    input  logic [7:0] code,
    output logic [3:0] hex,
    output logic       legal
);

    logic [1:0] row;
    logic [1:0] col;

    always_comb begin
        row = 2'd0;
        col = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (code[i])     row = 2'(i);
            if (code[4 + i]) col = 2'(i);
        end
        hex   = key_lookup(row, col);
        legal = onehot4(code[7:4]) && onehot4(code[3:0]);
    end

endmodule

// File: rtl/keypad_debouncer.sv
// Debounces scanner press codes and emits a one-cycle keyvalid pulse plus a two-digit history.
// Define KEYPAD_RELEASE_DEBOUNCE_EN to also require a debounced release before the next press.
module keypad_debouncer
    import keypad_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 20000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] currentpress,
    input  logic       rowpressed,
    output logic       keyvalid,
    output logic [3:0] keycode,
    output logic [7:0] digits
);

    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CntW-1:0] CntTarget = CntW'(DEBOUNCE_CYCLES);

    kd_state_t       state;
    logic [CntW-1:0] cnt;
    logic [7:0]      cap;

    logic [3:0]      hex;
    logic            code_legal;
    logic            legal;
    logic            match;
    logic [CntW-1:0] cnt_inc;

    // Entry to HELD only happens while currentpress == cap, so decoding the live input suffices.
    keypad_decode u_decode (
        .code  (currentpress),
        .hex   (hex),
        .legal (code_legal)
    );

    assign legal   = code_legal && rowpressed;
    assign match   = rowpressed && (currentpress == cap);
    assign cnt_inc = (cnt == CntTarget) ? cnt : cnt + CntW'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= StIdle;
            cnt      <= '0;
            cap      <= 8'h00;
            keyvalid <= 1'b0;
            keycode  <= 4'h0;
            digits   <= 8'h00;
        end else begin
            keyvalid <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (legal) begin
                        cap   <= currentpress;
                        cnt   <= '0;
                        state <= StDebounce;
                    end
                end
                StDebounce: begin
                    if (!match) begin
                        state <= StIdle;
                    end else begin
                        cnt <= cnt_inc;
                        if (cnt_inc == CntTarget) begin
                            state    <= StHeld;
                            keyvalid <= 1'b1;
                            keycode  <= hex;
                            digits   <= {hex, digits[7:4]};
                        end
                    end
                end
                StHeld: begin
                    if (!match) begin
`ifdef KEYPAD_RELEASE_DEBOUNCE_EN
                        // The mismatch that leaves HELD is the first counted release sample.
                        if (CntTarget == CntW'(1)) begin
                            state <= StIdle;
                        end else begin
                            state <= StRelease;
                            cnt   <= CntW'(1);
                        end
`else
                        state <= StIdle;
`endif
                    end
                end
`ifdef KEYPAD_RELEASE_DEBOUNCE_EN
                StRelease: begin
                    if (match) begin
                        cnt <= '0;
                    end else begin
                        cnt <= cnt_inc;
                        if (cnt_inc == CntTarget) state <= StIdle;
                    end
                end
`endif
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_debouncer.sv
// Randomized and directed bench for keypad_debouncer against a run-length reference model.
module tb_keypad_debouncer;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] currentpress = 8'h00;
    logic       rowpressed = 1'b0;
    logic       keyvalid;
    logic [3:0] keycode;
    logic [7:0] digits;

    keypad_debouncer #(.DEBOUNCE_CYCLES(D)) dut (
        .clk          (clk),
        .reset        (reset),
        .currentpress (currentpress),
        .rowpressed   (rowpressed),
        .keyvalid     (keyvalid),
        .keycode      (keycode),
        .digits       (digits)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int step_idx = -1;
    int pulse_cnt = 0;
    int pulse_at = -1;
    bit cmp_en = 1'b0;

    // Row-major key table, row r / column c at index r*4+c.
    logic [3:0] keys [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                              4'h4, 4'h5, 4'h6, 4'hB,
                              4'h7, 4'h8, 4'h9, 4'hC,
                              4'hE, 4'h0, 4'hF, 4'hD};

    // Reference model: length of the current stable legal run, and a release-run counter once locked.
    int         m_streak;
    logic [7:0] m_code;
    bit         m_locked;
    int         m_rel;
    logic       m_kv;
    logic [3:0] m_kc;
    logic [7:0] m_dg;

    function automatic bit is_legal(input logic [7:0] cp, input logic rp);
        return rp && ($countones(cp[7:4]) == 1) && ($countones(cp[3:0]) == 1);
    endfunction

    function automatic logic [3:0] key_of(input logic [7:0] cp);
        logic [3:0] k;
        k = 4'h0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (cp[r] && cp[4 + c]) k = keys[r * 4 + c];
        return k;
    endfunction

    task automatic model_reset();
        m_streak = 0;
        m_code   = 8'h00;
        m_locked = 1'b0;
        m_rel    = 0;
        m_kv     = 1'b0;
        m_kc     = 4'h0;
        m_dg     = 8'h00;
    endtask

    task automatic model_step(input logic [7:0] cp, input logic rp);
        bit same;
        same = rp && (cp == m_code);
        m_kv = 1'b0;
        if (m_locked) begin
            if (same) begin
                m_rel = 0;
            end else begin
`ifdef KEYPAD_RELEASE_DEBOUNCE_EN
                m_rel++;
                if (m_rel >= D) begin
                    m_locked = 1'b0;
                    m_streak = 0;
                end
`else
                m_locked = 1'b0;
                m_streak = 0;
`endif
            end
        end else if (m_streak == 0) begin
            if (is_legal(cp, rp)) begin
                m_code   = cp;
                m_streak = 1;
            end
        end else if (same) begin
            m_streak++;
            if (m_streak == D + 1) begin
                m_kv     = 1'b1;
                m_kc     = key_of(cp);
                m_dg     = {key_of(cp), m_dg[7:4]};
                m_locked = 1'b1;
                m_rel    = 0;
            end
        end else begin
            m_streak = 0;
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            n_cmp++;
            if (keyvalid !== m_kv || keycode !== m_kc || digits !== m_dg) begin
                n_err++;
                $display("FAIL model_cmp step %0d: got kv=%b kc=%h dg=%h, want kv=%b kc=%h dg=%h",
                         step_idx, keyvalid, keycode, digits, m_kv, m_kc, m_dg);
            end
            if (keyvalid === 1'b1) begin
                pulse_cnt++;
                pulse_at = step_idx;
            end
        end
    end

    task automatic step(input logic [7:0] cp, input logic rp);
        currentpress = cp;
        rowpressed   = rp;
        @(posedge clk);
        step_idx++;
        model_step(cp, rp);
        #1;
    endtask

    task automatic run(input logic [7:0] cp, input logic rp, input int n);
        for (int i = 0; i < n; i++) step(cp, rp);
    endtask

    task automatic do_reset(input bit check_zero);
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        if (check_zero) begin
            chk("rst_keyvalid", int'(keyvalid), 0);
            chk("rst_keycode", int'(keycode), 0);
            chk("rst_digits", int'(digits), 0);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        int s;
        int len;
        logic [7:0] code;
        model_reset();
        #1;
        cmp_en = 1'b1;
        do_reset(1'b1);

        // Scenario 1: steady key 1.
        pulse_cnt = 0;
        s = step_idx + 1;
        run(8'h11, 1'b1, 12);
        chk("s1_pulses", pulse_cnt, 1);
        chk("s1_pulse_at", pulse_at, s + D);
        chk("s1_keycode", int'(keycode), 4'h1);
        chk("s1_digits", int'(digits), 8'h10);

        // Scenario 3: release, then key C.
        run(8'h00, 1'b0, 6);
        pulse_cnt = 0;
        run(8'h84, 1'b1, 8);
        chk("s3_pulses", pulse_cnt, 1);
        chk("s3_keycode", int'(keycode), 4'hC);
        chk("s3_digits", int'(digits), 8'hC1);

        // Scenario 4: illegal multi-row code.
        run(8'h00, 1'b0, 6);
        pulse_cnt = 0;
        run(8'h13, 1'b1, 20);
        chk("s4_pulses", pulse_cnt, 0);
        chk("s4_keycode", int'(keycode), 4'hC);
        chk("s4_digits", int'(digits), 8'hC1);

        // Scenario 2: bounce on key 5.
        do_reset(1'b0);
        pulse_cnt = 0;
        run(8'h22, 1'b1, 3);
        run(8'h22, 1'b0, 1);
        s = step_idx + 1;
        run(8'h22, 1'b1, 8);
        chk("s2_pulses", pulse_cnt, 1);
        chk("s2_pulse_at", pulse_at, s + D);
        chk("s2_keycode", int'(keycode), 4'h5);

        // Scenario 5: reset while HELD on key 5, key still held.
        currentpress = 8'h22;
        rowpressed   = 1'b1;
        do_reset(1'b1);
        pulse_cnt = 0;
        s = step_idx + 1;
        run(8'h22, 1'b1, 8);
        chk("s5_pulses", pulse_cnt, 1);
        chk("s5_pulse_at", pulse_at, s + D);
        chk("s5_keycode", int'(keycode), 4'h5);
        chk("s5_digits", int'(digits), 8'h50);

        // Scenario 6: short drop while HELD on key 1.
        do_reset(1'b0);
        run(8'h11, 1'b1, 8);
        pulse_cnt = 0;
        run(8'h00, 1'b0, 2);
        s = step_idx + 1;
        run(8'h11, 1'b1, 6);
`ifdef KEYPAD_RELEASE_DEBOUNCE_EN
        chk("s6_pulses", pulse_cnt, 0);
`else
        chk("s6_pulses", pulse_cnt, 1);
        chk("s6_pulse_at", pulse_at, s + D);
`endif

        // Random bursts: mostly legal keys with row glitches, some garbage codes, rare resets.
        do_reset(1'b0);
        for (int b = 0; b < 400; b++) begin
            len = $urandom_range(1, 10);
            if ($urandom_range(0, 9) < 7)
                code = {4'(1 << $urandom_range(0, 3)), 4'(1 << $urandom_range(0, 3))};
            else
                code = 8'($urandom);
            if ($urandom_range(0, 99) == 0) do_reset(1'b0);
            for (int i = 0; i < len; i++) step(code, 1'($urandom_range(0, 9) != 0));
        end

        @(negedge clk);
        cmp_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
